pixel_stream_processor: RTL and testbench

Parametrised streaming successor to the frame-buffer pixel processor. It accepts pixels on a valid/ready stream, applies one of five point operations in a 2-stage pipeline with full backpressure, and emits the result on a valid/ready output stream. Raster position is tracked so that end-of-line, end-of-frame and a frame-done pulse are generated. It sits between the pixel source (DMA/line reader) and the frame writer; there is no internal frame memory.

---
 rtl/pixel_stream_processor.sv | 156 +++++++++++++++
 tb/tb_pixel_stream_processor.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_processor.sv
// Streaming point-operation pixel processor: two-stage valid/ready pipeline with
// raster tracking (eol/eof/frame_done) and a per-frame configuration shadow.
module pixel_stream_processor #(
    parameter int unsigned CH_WIDTH     = 8,
    parameter int unsigned NUM_CH       = 3,
    parameter int unsigned IMAGE_WIDTH  = 512,
    parameter int unsigned IMAGE_HEIGHT = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 cfg_op,
    input  logic [CH_WIDTH-1:0]        cfg_threshold,
    input  logic [CH_WIDTH-1:0]        cfg_brightness,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [NUM_CH*CH_WIDTH-1:0] s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [NUM_CH*CH_WIDTH-1:0] m_data,
    output logic                       m_eol,
    output logic                       m_eof,
    output logic                       frame_done,
    output logic                       busy
);
    localparam int unsigned DW = NUM_CH * CH_WIDTH;
    localparam int unsigned GW = CH_WIDTH + 8;
    localparam int unsigned XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMAGE_HEIGHT - 1);
    localparam logic [CH_WIDTH-1:0] MAX = '1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]          state;
    logic [XW-1:0]       x;
    logic [YW-1:0]       y;
    logic [2:0]          op_q;
    logic [CH_WIDTH-1:0] thr_q;
    logic [CH_WIDTH-1:0] bri_q;
    logic                s1_valid;
    logic                s1_eol;
    logic                s1_eof;
    logic [DW-1:0]       s1_data;

    logic                advance;
    logic                in_beat;
    logic                out_beat;
    logic                first_px;
    logic                last_x;
    logic                last_px;
    logic [2:0]          op_eff;
    logic [CH_WIDTH-1:0] thr_eff;
    logic [CH_WIDTH-1:0] bri_eff;
    logic [CH_WIDTH-1:0] gray;
    logic [CH_WIDTH-1:0] ch;
    logic [CH_WIDTH+1:0] bsum;
    logic [DW-1:0]       result;

    assign advance  = !m_valid || m_ready;
    assign s_ready  = (state != ST_DRAIN) && (!s1_valid || advance);
    assign in_beat  = s_valid && s_ready;
    assign out_beat = m_valid && m_ready;
    assign busy     = (state != ST_IDLE);
    assign first_px = (x == '0) && (y == '0);
    assign last_x   = (x == X_LAST);
    assign last_px  = last_x && (y == Y_LAST);

    // Pixel (0,0) uses the live config; the shadow carries it through the rest of the frame.
    assign op_eff  = first_px ? cfg_op : op_q;
    assign thr_eff = first_px ? cfg_threshold : thr_q;
    assign bri_eff = first_px ? cfg_brightness : bri_q;

    generate
        if (NUM_CH == 3) begin : g_gray
            logic [GW-1:0] gsum;
            assign gsum = GW'(77) * GW'(s_data[DW-1 -: CH_WIDTH])
                        + GW'(150) * GW'(s_data[2*CH_WIDTH-1 -: CH_WIDTH])
                        + GW'(29) * GW'(s_data[CH_WIDTH-1:0]);
            assign gray = gsum[GW-1:8];
        end else begin : g_no_gray
            assign gray = '0;
        end
    endgenerate

    always_comb begin
        result = s_data;
        ch     = '0;
        bsum   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch   = s_data[i*CH_WIDTH +: CH_WIDTH];
            bsum = {2'b00, ch} + {{2{bri_eff[CH_WIDTH-1]}}, bri_eff};
            case (op_eff)
                3'd0: result[i*CH_WIDTH +: CH_WIDTH] = MAX - ch;
                3'd1: result[i*CH_WIDTH +: CH_WIDTH] = (ch > thr_eff) ? MAX : '0;
                3'd2: result[i*CH_WIDTH +: CH_WIDTH] =
                          bsum[CH_WIDTH+1] ? '0 : (bsum[CH_WIDTH] ? MAX : bsum[CH_WIDTH-1:0]);
                3'd3: result[i*CH_WIDTH +: CH_WIDTH] = (NUM_CH == 3) ? gray : ch;
                default: result[i*CH_WIDTH +: CH_WIDTH] = ch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            x          <= '0;
            y          <= '0;
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_eol     <= 1'b0;
            s1_eof     <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= out_beat && m_eof;

            if (in_beat) begin
                s1_valid <= 1'b1;
                s1_data  <= result;
                s1_eol   <= last_x;
                s1_eof   <= last_px;
                x        <= last_x ? '0 : x + 1'b1;
                if (last_x) begin
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end
                if (first_px) begin
                    op_q  <= cfg_op;
                    thr_q <= cfg_threshold;
                    bri_q <= cfg_brightness;
                end
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (advance) begin
                m_valid <= s1_valid;
                m_data  <= s1_data;
                m_eol   <= s1_eol;
                m_eof   <= s1_eof;
            end

            case (state)
                ST_IDLE:  if (in_beat) state <= last_px ? ST_DRAIN : ST_RUN;
                ST_RUN:   if (in_beat && last_px) state <= ST_DRAIN;
                ST_DRAIN: if (out_beat && m_eof) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_stream_processor.sv
// Randomised self-checking bench for pixel_stream_processor on a 4x2 RGB888 image.
module tb_pixel_stream_processor;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  cfg_op;
    logic [7:0]  cfg_threshold;
    logic [7:0]  cfg_brightness;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic        m_eol;
    logic        m_eof;
    logic        frame_done;
    logic        busy;

    pixel_stream_processor #(
        .CH_WIDTH    (8),
        .NUM_CH      (3),
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_op        (cfg_op),
        .cfg_threshold (cfg_threshold),
        .cfg_brightness(cfg_brightness),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_eol         (m_eol),
        .m_eof         (m_eof),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] pix_in[64];
    logic [23:0] obs_data[64];
    bit          obs_eol[64];
    bit          obs_eof[64];
    int          in_cyc[64];
    int          out_cyc[64];
    int          e_op[64];
    int          e_thr[64];
    int          e_bri[64];
    int          n_in, n_out, done_cyc, done_cnt, unstable, sready_low, held_at_low;
    bit          timed_out, busy_mid, busy_at_done;

    // Reference: per-channel arithmetic straight from the operation definitions.
    function automatic logic [23:0] ref_pix(input int op, input int thr, input int bri,
                                            input logic [23:0] p);
        int c[3];
        int r[3];
        int off;
        int g;
        c[0] = int'(p[23:16]);
        c[1] = int'(p[15:8]);
        c[2] = int'(p[7:0]);
        off  = (bri >= 128) ? bri - 256 : bri;
        g    = (77 * c[0] + 150 * c[1] + 29 * c[2]) / 256;
        for (int i = 0; i < 3; i++) begin
            case (op)
                0: r[i] = 255 - c[i];
                1: r[i] = (c[i] > thr) ? 255 : 0;
                2: begin
                    r[i] = c[i] + off;
                    if (r[i] < 0) r[i] = 0;
                    if (r[i] > 255) r[i] = 255;
                end
                3: r[i] = g;
                default: r[i] = c[i];
            endcase
        end
        return {8'(r[0]), 8'(r[1]), 8'(r[2])};
    endfunction

    // Drives n pixels from pix_in and records every handshake; call at a negedge.
    task automatic run_stream(input int n, input int stall_start, input int stall_len,
                              input bit rnd_ready, input int chg_at, input int chg_op);
        bit          pend = 0;
        bit          prev_hold = 0;
        logic [23:0] prev_data = '0;
        bit          prev_eol = 0, prev_eof = 0;
        int          lop = 0, lthr = 0, lbri = 0, last_out_c = 0;
        n_in = 0; n_out = 0; done_cyc = -1; done_cnt = 0; unstable = 0;
        sready_low = 0; held_at_low = -1; timed_out = 1; busy_mid = 0; busy_at_done = 1;
        for (int c = 0; c < 400; c++) begin
            s_valid = (n_in < n);
            s_data  = s_valid ? pix_in[n_in] : 24'h0;
            if (rnd_ready) m_ready = ($urandom_range(3) != 0);
            else m_ready = !(c >= stall_start && c < stall_start + stall_len);
            #1;
            if (prev_hold && ({m_valid, m_data, m_eol, m_eof} !==
                              {1'b1, prev_data, prev_eol, prev_eof})) unstable++;
            if (s_valid && !s_ready) begin
                sready_low++;
                if (held_at_low < 0) held_at_low = n_in - n_out;
            end
            if (frame_done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = c;
                    busy_at_done = busy;
                end
            end
            if (n_in > 0 && c == in_cyc[0] + 1) busy_mid = busy;
            if (s_valid && s_ready) begin
                if (n_in % NPIX == 0) begin
                    lop  = int'(cfg_op);
                    lthr = int'(cfg_threshold);
                    lbri = int'(cfg_brightness);
                end
                e_op[n_in]   = lop;
                e_thr[n_in]  = lthr;
                e_bri[n_in]  = lbri;
                in_cyc[n_in] = c;
                n_in++;
                if (n_in == chg_at) pend = 1;
            end
            if (m_valid && m_ready) begin
                obs_data[n_out] = m_data;
                obs_eol[n_out]  = m_eol;
                obs_eof[n_out]  = m_eof;
                out_cyc[n_out]  = c;
                n_out++;
                last_out_c = c;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            prev_eol  = m_eol;
            prev_eof  = m_eof;
            if (n_out == n && c >= last_out_c + 3) begin
                timed_out = 0;
                break;
            end
            @(posedge clk);
            if (pend) begin
                cfg_op = 3'(chg_op);
                pend   = 0;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({m_valid, m_eol, m_eof} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 000", {m_valid, m_eol, m_eof});
        end
        n_cmp++;
        if (m_data !== 24'h0) begin
            n_err++;
            $display("FAIL reset_data: got %h want 000000", m_data);
        end
        n_cmp++;
        if ({frame_done, busy, s_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 001", {frame_done, busy, s_ready});
        end
        rst = 1'b0;
    endtask

    task automatic test_invert_stream();
        cfg_op = 3'd0;
        for (int i = 0; i < NPIX; i++) pix_in[i] = 24'h102030;
        run_stream(NPIX, 999, 0, 0, -1, 0);
        n_cmp++;
        if (timed_out) begin n_err++; $display("FAIL inv_timeout: got 1 want 0"); end
        for (int i = 0; i < NPIX; i++) begin
            n_cmp++;
            if ({obs_data[i], obs_eol[i], obs_eof[i]} !==
                {24'hEFDFCF, (i % W) == W - 1, i == NPIX - 1}) begin
                n_err++;
                $display("FAIL inv_px%0d: got %h/%b%b want efdfcf/%b%b", i, obs_data[i],
                         obs_eol[i], obs_eof[i], (i % W) == W - 1, i == NPIX - 1);
            end
        end
        n_cmp++;
        if (out_cyc[0] - in_cyc[0] != 2) begin
            n_err++;
            $display("FAIL inv_latency: got %0d want 2", out_cyc[0] - in_cyc[0]);
        end
        n_cmp++;
        if (in_cyc[NPIX-1] - in_cyc[0] != NPIX - 1 || out_cyc[NPIX-1] - out_cyc[0] != NPIX - 1)
        begin
            n_err++;
            $display("FAIL inv_throughput: got %0d/%0d want %0d", in_cyc[NPIX-1] - in_cyc[0],
                     out_cyc[NPIX-1] - out_cyc[0], NPIX - 1);
        end
        n_cmp++;
        if (done_cyc != out_cyc[NPIX-1] + 1 || done_cnt != 1) begin
            n_err++;
            $display("FAIL inv_frame_done: got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc,
                     done_cnt, out_cyc[NPIX-1] + 1);
        end
        n_cmp++;
        if ({busy_mid, busy_at_done} !== 2'b10) begin
            n_err++;
            $display("FAIL inv_busy: got %b want 10", {busy_mid, busy_at_done});
        end
    endtask

    task automatic test_ops();
        int          fop[4];
        int          fthr[4];
        int          fbri[4];
        logic [23:0] din[4];
        logic [23:0] dout[4];
        logic [23:0] exp_px;
        fop  = '{2, 2, 1, 3};
        fthr = '{0, 0, 8'h80, 0};
        fbri = '{8'h28, 8'hD8, 0, 0};
        din  = '{24'hF00A80, 24'h10FF30, 24'h8081FF, 24'hFF0000};
        dout = '{24'hFF32A8, 24'h00D708, 24'h00FFFF, 24'h4C4C4C};
        for (int f = 0; f < 10; f++) begin
            if (f < 4) begin
                cfg_op         = 3'(fop[f]);
                cfg_threshold  = 8'(fthr[f]);
                cfg_brightness = 8'(fbri[f]);
            end else begin
                cfg_op         = 3'($urandom_range(7));
                cfg_threshold  = 8'($urandom);
                cfg_brightness = 8'($urandom);
            end
            for (int i = 0; i < NPIX; i++) pix_in[i] = 24'($urandom);
            if (f < 4) pix_in[0] = din[f];
            if (f == 3) pix_in[1] = 24'hFFFFFF;
            run_stream(NPIX, 999, 0, f >= 4, -1, 0);
            n_cmp++;
            if (timed_out) begin n_err++; $display("FAIL ops_timeout f%0d: got 1 want 0", f); end
            if (f < 4) begin
                n_cmp++;
                if (obs_data[0] !== dout[f]) begin
                    n_err++;
                    $display("FAIL ops_directed f%0d: got %h want %h", f, obs_data[0], dout[f]);
                end
            end
            if (f == 3) begin
                n_cmp++;
                if (obs_data[1] !== 24'hFFFFFF) begin
                    n_err++;
                    $display("FAIL ops_gray_white: got %h want ffffff", obs_data[1]);
                end
            end
            for (int i = 0; i < NPIX; i++) begin
                exp_px = ref_pix(e_op[i], e_thr[i], e_bri[i], pix_in[i]);
                n_cmp++;
                if ({obs_data[i], obs_eol[i], obs_eof[i]} !==
                    {exp_px, (i % W) == W - 1, i == NPIX - 1}) begin
                    n_err++;
                    $display("FAIL ops f%0d px%0d op%0d: got %h/%b%b want %h/%b%b", f, i,
                             e_op[i], obs_data[i], obs_eol[i], obs_eof[i], exp_px,
                             (i % W) == W - 1, i == NPIX - 1);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        cfg_op = 3'd0;
        for (int i = 0; i < NPIX; i++) pix_in[i] = 24'($urandom);
        run_stream(NPIX, 3, 5, 0, -1, 0);
        n_cmp++;
        if (timed_out) begin n_err++; $display("FAIL bp_timeout: got 1 want 0"); end
        for (int i = 0; i < NPIX; i++) begin
            n_cmp++;
            if (obs_data[i] !== (24'hFFFFFF ^ pix_in[i])) begin
                n_err++;
                $display("FAIL bp_order px%0d: got %h want %h", i, obs_data[i],
                         24'hFFFFFF ^ pix_in[i]);
            end
        end
        n_cmp++;
        if (unstable != 0) begin
            n_err++;
            $display("FAIL bp_stable: got %0d changes want 0", unstable);
        end
        n_cmp++;
        if (held_at_low != 2 || sready_low != 5) begin
            n_err++;
            $display("FAIL bp_sready: got held %0d low %0d want held 2 low 5", held_at_low,
                     sready_low);
        end
    endtask

    task automatic test_cfg_latch_drain();
        logic [23:0] exp_px;
        cfg_op = 3'd0;
        for (int i = 0; i < 2 * NPIX; i++) pix_in[i] = 24'($urandom);
        run_stream(2 * NPIX, 999, 0, 0, 3, 4);
        n_cmp++;
        if (timed_out) begin n_err++; $display("FAIL cfg_timeout: got 1 want 0"); end
        for (int i = 0; i < 2 * NPIX; i++) begin
            exp_px = (i < NPIX) ? (24'hFFFFFF ^ pix_in[i]) : pix_in[i];
            n_cmp++;
            if (obs_data[i] !== exp_px) begin
                n_err++;
                $display("FAIL cfg_latch px%0d: got %h want %h", i, obs_data[i], exp_px);
            end
        end
        n_cmp++;
        if (in_cyc[NPIX] != done_cyc || sready_low != 2 || done_cnt != 2) begin
            n_err++;
            $display("FAIL cfg_drain: got in8 %0d done %0d low %0d cnt %0d want in8=done low 2 cnt 2",
                     in_cyc[NPIX], done_cyc, sready_low, done_cnt);
        end
    endtask

    task automatic test_midframe_reset();
        logic [23:0] exp_px;
        cfg_op  = 3'd4;
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 24'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({m_valid, m_eol, m_eof, frame_done, busy, s_ready} !== 6'b000001 || m_data !== 24'h0)
        begin
            n_err++;
            $display("FAIL mrst_state: got %b/%h want 000001/000000",
                     {m_valid, m_eol, m_eof, frame_done, busy, s_ready}, m_data);
        end
        cfg_op = 3'd1;
        cfg_threshold = 8'($urandom);
        for (int i = 0; i < NPIX; i++) pix_in[i] = 24'($urandom);
        run_stream(NPIX, 999, 0, 0, -1, 0);
        n_cmp++;
        if (timed_out) begin n_err++; $display("FAIL mrst_timeout: got 1 want 0"); end
        for (int i = 0; i < NPIX; i++) begin
            exp_px = ref_pix(1, int'(cfg_threshold), 0, pix_in[i]);
            n_cmp++;
            if ({obs_data[i], obs_eof[i]} !== {exp_px, i == NPIX - 1}) begin
                n_err++;
                $display("FAIL mrst px%0d: got %h/%b want %h/%b", i, obs_data[i], obs_eof[i],
                         exp_px, i == NPIX - 1);
            end
        end
        n_cmp++;
        if (done_cnt != 1) begin
            n_err++;
            $display("FAIL mrst_done: got %0d want 1", done_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        cfg_op         = 3'd4;
        cfg_threshold  = 8'h00;
        cfg_brightness = 8'h00;
        s_valid        = 1'b0;
        s_data         = 24'h0;
        m_ready        = 1'b1;
        test_reset();
        test_invert_stream();
        test_ops();
        test_backpressure();
        test_cfg_latch_drain();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
